// File: rtl/issue_sched.sv
// Two-lane in-order issue queue: circular FIFO feeding a two-entry issue register.
// Define ISSUE_DUAL_EN for two-wide issue; otherwise only lane 0 issues.
module issue_sched #(
    parameter  int QDEPTH = 8,
    parameter  int PW     = 64,
    localparam int EW     = PW + 19,
    localparam int AW     = $clog2(QDEPTH),
    localparam int CW     = AW + 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic [1:0]      enq_valid,
    input  logic [2*EW-1:0] enq_entry,
    output logic            enq_ready,
    output logic [9:0]      head_ra1,
    output logic [9:0]      head_ra2,
    input  logic [1:0]      src1_ok,
    input  logic [1:0]      src2_ok,
    input  logic            deq_ready,
    output logic [1:0]      deq_valid,
    output logic [2*EW-1:0] deq_entry,
    output logic [CW-1:0]   count
);

    // Entry layout, MSB to LSB: payload, ra1, ra2, rdst, regwrite, use1, use2, mem
    localparam int B_MEM    = 0;
    localparam int B_USE2   = 1;
    localparam int B_USE1   = 2;
    localparam int B_RW     = 3;
    localparam int RDST_LSB = 4;
    localparam int RA2_LSB  = 9;
    localparam int RA1_LSB  = 14;

`ifdef ISSUE_DUAL_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic [EW-1:0]   r_mem [QDEPTH];
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_wr;
    logic [CW-1:0]   r_count;
    logic [1:0]      r_deq_valid;
    logic [2*EW-1:0] r_deq_entry;

    logic [EW-1:0]   w_head [2];
    logic [1:0]      w_hvalid;
    logic [1:0]      w_hready;
    logic            w_enq;
    logic [CW-1:0]   w_enq_n;
    logic [CW-1:0]   w_iss_n;
    logic            w_issue0;
    logic            w_issue1;
    logic            w_raw;
    logic            w_pair_ok;
    logic [4:0]      w_h0_rdst;

    for (genvar gi = 0; gi < 2; gi++) begin : g_head
        assign w_head[gi]   = r_mem[AW'(r_rd + AW'(gi))];
        assign w_hvalid[gi] = (r_count > CW'(gi));
        assign w_hready[gi] = (!w_head[gi][B_USE1] || src1_ok[gi]) &&
                              (!w_head[gi][B_USE2] || src2_ok[gi]);
        assign head_ra1[5*gi +: 5] = w_head[gi][RA1_LSB +: 5];
        assign head_ra2[5*gi +: 5] = w_head[gi][RA2_LSB +: 5];
    end

    assign enq_ready = ((CW'(QDEPTH) - r_count) >= CW'(2));
    assign w_enq     = enq_valid[0] && enq_ready && !flush;
    assign w_enq_n   = !w_enq ? CW'(0) : (enq_valid[1] ? CW'(2) : CW'(1));

    // Head 1 may not read a register that head 0 is about to write.
    assign w_h0_rdst = w_head[0][RDST_LSB +: 5];
    assign w_raw     = w_head[0][B_RW] && (w_h0_rdst != 5'd0) &&
                       ((w_head[1][B_USE1] && (w_head[1][RA1_LSB +: 5] == w_h0_rdst)) ||
                        (w_head[1][B_USE2] && (w_head[1][RA2_LSB +: 5] == w_h0_rdst)));
    assign w_pair_ok = w_hvalid[1] && w_hready[1] && !w_raw &&
                       !(w_head[0][B_MEM] && w_head[1][B_MEM]);

    assign w_issue0 = w_hvalid[0] && w_hready[0] && (deq_ready || !r_deq_valid[0]);
    assign w_issue1 = DUAL && w_issue0 && w_pair_ok;
    assign w_iss_n  = CW'(w_issue0) + CW'(w_issue1);

    // Storage carries no reset; occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr] <= enq_entry[EW-1:0];
            if (enq_valid[1]) begin
                r_mem[AW'(r_wr + AW'(1))] <= enq_entry[2*EW-1:EW];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd        <= '0;
            r_wr        <= '0;
            r_count     <= '0;
            r_deq_valid <= '0;
            r_deq_entry <= '0;
        end else if (flush) begin
            r_rd        <= '0;
            r_wr        <= '0;
            r_count     <= '0;
            r_deq_valid <= '0;
        end else begin
            r_wr    <= r_wr + w_enq_n[AW-1:0];
            r_rd    <= r_rd + w_iss_n[AW-1:0];
            r_count <= r_count + w_enq_n - w_iss_n;
            if (w_issue0) begin
                r_deq_valid <= {w_issue1, 1'b1};
                r_deq_entry <= {w_head[1], w_head[0]};
            end else if (deq_ready || !r_deq_valid[0]) begin
                r_deq_valid <= 2'b00;
            end
        end
    end

    assign deq_valid = r_deq_valid;
    assign deq_entry = r_deq_entry;
    assign count     = r_count;

endmodule

// File: tb/tb_issue_sched.sv
// Directed self-checking bench for issue_sched; expectations follow ISSUE_DUAL_EN.
module tb_issue_sched;

    localparam int PW = 64;
    localparam int EW = PW + 19;

`ifdef ISSUE_DUAL_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic            clk;
    logic            resetn;
    logic            flush;
    logic [1:0]      enq_valid;
    logic [2*EW-1:0] enq_entry;
    logic            enq_ready;
    logic [9:0]      head_ra1;
    logic [9:0]      head_ra2;
    logic [1:0]      src1_ok;
    logic [1:0]      src2_ok;
    logic            deq_ready;
    logic [1:0]      deq_valid;
    logic [2*EW-1:0] deq_entry;
    logic [3:0]      count;

    int tests = 0;
    int fails = 0;

    issue_sched #(.QDEPTH(8), .PW(PW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_entry (enq_entry),
        .enq_ready (enq_ready),
        .head_ra1  (head_ra1),
        .head_ra2  (head_ra2),
        .src1_ok   (src1_ok),
        .src2_ok   (src2_ok),
        .deq_ready (deq_ready),
        .deq_valid (deq_valid),
        .deq_entry (deq_entry),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            tests++;
            if (enq_ready !== ((4'd8 - count) >= 4'd2)) begin
                fails++;
                $error("FAIL inv_enq_ready: enq_ready %0b count %0d", enq_ready, count);
            end
            tests++;
            if (count > 4'd8) begin
                fails++;
                $error("FAIL inv_count_range: count %0d", count);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    `define CHK(t, o, e) check(t, 256'(o), 256'(e))

    function automatic logic [EW-1:0] mk(input logic [PW-1:0] pay, input int ra1, input int ra2,
                                         input int rdst, input bit rw, input bit u1,
                                         input bit u2, input bit m);
        return {pay, 5'(ra1), 5'(ra2), 5'(rdst), rw, u1, u2, m};
    endfunction

    logic [EW-1:0] e_a, e_b, e_c, e_d, e_f, e_m1, e_m2, e_g, e_h, e_i, e_j;
    logic [EW-1:0] e_p [7];
    int base;

    initial begin
        resetn = 1'b0; flush = 1'b0; enq_valid = 2'b00; enq_entry = '0;
        src1_ok = 2'b11; src2_ok = 2'b11; deq_ready = 1'b1;
        e_a  = mk(64'hA0, 1, 2, 3, 1, 1, 1, 0);
        e_b  = mk(64'hB0, 4, 6, 7, 1, 1, 1, 0);
        e_c  = mk(64'hC0, 1, 2, 5, 1, 0, 0, 0);
        e_d  = mk(64'hD0, 5, 0, 6, 1, 1, 0, 0);
        e_f  = mk(64'hF0, 0, 9, 0, 0, 0, 1, 0);
        e_m1 = mk(64'hE1, 1, 0, 8, 1, 0, 0, 1);
        e_m2 = mk(64'hE2, 2, 0, 9, 1, 0, 0, 1);
        e_g  = mk(64'h610, 1, 2, 10, 1, 1, 1, 0);
        e_h  = mk(64'h611, 1, 2, 11, 1, 1, 1, 0);
        e_i  = mk(64'h612, 1, 2, 12, 1, 1, 1, 0);
        e_j  = mk(64'h613, 1, 2, 13, 1, 1, 1, 0);
        for (int k = 0; k < 7; k++) e_p[k] = mk(64'h100 + 64'(k), k + 1, 0, 0, 0, 1, 0, 0);

        repeat (2) tick();
        `CHK("rst_count", count, 0);
        `CHK("rst_deq_valid", deq_valid, 0);
        `CHK("rst_deq_entry", deq_entry, 0);
        `CHK("rst_enq_ready", enq_ready, 1);
        resetn = 1'b1;
        tick();

        // Two independent ALU entries
        enq_valid = 2'b11; enq_entry = {e_b, e_a};
        tick();
        enq_valid = 2'b00;
        `CHK("A_count_enq", count, 2);
        `CHK("A_dv_latency", deq_valid, 0);
        `CHK("A_head_ra1", head_ra1, {5'd4, 5'd1});
        `CHK("A_head_ra2", head_ra2, {5'd6, 5'd2});
        tick();
        `CHK("A_dv_issue", deq_valid, DUAL ? 2'b11 : 2'b01);
        `CHK("A_lane0", deq_entry[EW-1:0], e_a);
        `CHK("A_count_issue", count, DUAL ? 1'b0 : 1'b1);
        tick();
        `CHK("A_dv_after", deq_valid, DUAL ? 2'b00 : 2'b01);
        `CHK("A_count_empty", count, 0);

        // RAW hazard splits the pair
        enq_valid = 2'b11; enq_entry = {e_d, e_c};
        tick();
        enq_valid = 2'b00;
        `CHK("B_count_enq", count, 2);
        `CHK("B_dv_bubble", deq_valid, 0);
        tick();
        `CHK("B_dv_lane0", deq_valid, 2'b01);
        `CHK("B_lane0_c", deq_entry[EW-1:0], e_c);
        `CHK("B_count1", count, 1);
        tick();
        `CHK("B_dv_next", deq_valid, 2'b01);
        `CHK("B_lane0_d", deq_entry[EW-1:0], e_d);
        `CHK("B_count0", count, 0);
        tick();
        `CHK("B_dv_bubble2", deq_valid, 0);

        // Lane 1 without lane 0 is ignored
        enq_valid = 2'b10; enq_entry = {e_a, e_b};
        tick();
        enq_valid = 2'b00;
        `CHK("L1only_count", count, 0);

        // Operand stall on src2
        src2_ok = 2'b10;
        enq_valid = 2'b01; enq_entry = {{EW{1'b0}}, e_f};
        tick();
        enq_valid = 2'b00;
        `CHK("C_count_enq", count, 1);
        `CHK("C_head_ra2", head_ra2[4:0], 9);
        for (int i = 0; i < 3; i++) begin
            tick();
            `CHK("C_dv_stall", deq_valid, 0);
            `CHK("C_count_stall", count, 1);
        end
        src2_ok = 2'b11;
        tick();
        `CHK("C_dv_go", deq_valid, 2'b01);
        `CHK("C_lane0_f", deq_entry[EW-1:0], e_f);
        `CHK("C_count0", count, 0);

        // Fill to QDEPTH-1 across the pointer wrap
        src1_ok = 2'b00;
        for (int k = 0; k < 6; k += 2) begin
            enq_valid = 2'b11; enq_entry = {e_p[k+1], e_p[k]};
            tick();
        end
        enq_valid = 2'b01; enq_entry = {{EW{1'b0}}, e_p[6]};
        tick();
        enq_valid = 2'b00;
        `CHK("D_count7", count, 7);
        `CHK("D_enq_ready0", enq_ready, 0);
        `CHK("D_dv_blocked", deq_valid, 0);
        enq_valid = 2'b11; enq_entry = {e_a, e_b};
        tick();
        enq_valid = 2'b00;
        `CHK("D_count_dropped", count, 7);
        src1_ok = 2'b01;
        tick();
        `CHK("D_count6", count, 6);
        `CHK("D_enq_ready1", enq_ready, 1);
        `CHK("D_dv", deq_valid, 2'b01);
        `CHK("D_p0", deq_entry[EW-1:0], e_p[0]);
        for (int k = 1; k < 7; k++) begin
            tick();
            `CHK("D_order", deq_entry[EW-1:0], e_p[k]);
            `CHK("D_dv_seq", deq_valid, 2'b01);
        end
        `CHK("D_count_end", count, 0);
        src1_ok = 2'b11;

        // Two memory ops never issue together
        enq_valid = 2'b11; enq_entry = {e_m2, e_m1};
        tick();
        enq_valid = 2'b00;
        `CHK("M_count", count, 2);
        tick();
        `CHK("M_dv1", deq_valid, 2'b01);
        `CHK("M_lane0_m1", deq_entry[EW-1:0], e_m1);
        tick();
        `CHK("M_dv2", deq_valid, 2'b01);
        `CHK("M_lane0_m2", deq_entry[EW-1:0], e_m2);
        tick();
        `CHK("M_dv_bubble", deq_valid, 0);

        // Back-pressure holds the issue register while enqueue continues
        enq_valid = 2'b11; enq_entry = {e_h, e_g};
        tick();
        enq_valid = 2'b00;
        `CHK("E_count_enq", count, 2);
        deq_ready = 1'b0;
        tick();
        base = DUAL ? 0 : 1;
        `CHK("E_dv_issue", deq_valid, DUAL ? 2'b11 : 2'b01);
        `CHK("E_lane0_g", deq_entry[EW-1:0], e_g);
        `CHK("E_count_issue", count, base);
        for (int i = 0; i < 2; i++) begin
            enq_valid = 2'b11; enq_entry = {e_j, e_i};
            tick();
            `CHK("E_dv_hold", deq_valid, DUAL ? 2'b11 : 2'b01);
            `CHK("E_lane0_hold", deq_entry[EW-1:0], e_g);
            `CHK("E_count_hold", count, base + 2 * (i + 1));
        end

        // Flush beats a simultaneous enqueue
        flush = 1'b1; enq_valid = 2'b11; enq_entry = {e_j, e_i};
        tick();
        flush = 1'b0; enq_valid = 2'b00;
        `CHK("F_count", count, 0);
        `CHK("F_dv", deq_valid, 0);
        `CHK("F_enq_ready", enq_ready, 1);
        deq_ready = 1'b1;
        tick();
        `CHK("F_dv_empty", deq_valid, 0);
        `CHK("F_count_empty", count, 0);

        // Asynchronous reset in the middle of a cycle
        enq_valid = 2'b11; enq_entry = {e_h, e_g};
        tick();
        enq_valid = 2'b00;
        tick();
        deq_ready = 1'b0;
        `CHK("R_pre_lane0", deq_entry[EW-1:0], e_g);
        #2;
        resetn = 1'b0;
        #1;
        `CHK("R_async_count", count, 0);
        `CHK("R_async_dv", deq_valid, 0);
        `CHK("R_async_de", deq_entry, 0);
        `CHK("R_async_rdy", enq_ready, 1);
        tick();
        resetn = 1'b1; deq_ready = 1'b1;
        tick();
        `CHK("R_post_dv", deq_valid, 0);
        `CHK("R_post_count", count, 0);
        tick();
        `CHK("R_post_dv2", deq_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
